// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: load/store size codes and FSM states.
// Latency: none (types, constants and pure functions only).
// Backpressure: n/a.
package mem_pkg;

    // Funct3 access-size codes (bit 2 selects zero-extension for loads)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic f3_supported(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_supported = 1'b1;
            default:                        f3_supported = 1'b0;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        misaligned = ((f3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane selection: shifts the addressed byte/halfword down and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none. Ports: i_word (storage word), i_offset (byte offset),
// i_funct3 (size/sign), o_data (extended result).
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;

    always_comb begin
        w_shift = i_word >> {i_offset, 3'b000};
        o_data  = w_shift;
        case (i_funct3)
            F3_B:    o_data = {{24{w_shift[7]}},  w_shift[7:0]};
            F3_H:    o_data = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_BU:   o_data = {24'b0, w_shift[7:0]};
            F3_HU:   o_data = {16'b0, w_shift[15:0]};
            default: o_data = w_shift;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder: captures a read/write in IDLE, waits LATENCY cycles, pulses MemReady.
// Latency: request captured at edge N completes (MemReady high) in cycle N+1+LATENCY.
// Backpressure: requests are only sampled in IDLE; Busy is high otherwise.
// Ports: clk, reset (async, active-high), MemRead/MemWrite/Address/WriteData/Funct3 request,
// ReadData (extended load), MemReady (done pulse), Busy, AccessErr (valid with MemReady).
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [2:0]  Funct3,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        Busy,
    output logic        AccessErr
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_rd, r_wr, r_err;
    logic [31:0] r_addr, r_wdat, r_rdata;
    logic [2:0]  r_f3;

    logic        w_in_idle, w_capture, w_enter_resp;
    logic        w_eff_rd, w_eff_wr, w_eff_err;
    logic [31:0] w_eff_addr, w_eff_wdat;
    logic [2:0]  w_eff_f3;
    logic [AW-1:0] w_idx;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wlane, w_rword, w_load;
    logic        w_do_wr, w_do_rd;
    logic        w_unused;

    // Zero contents at time zero; reset deliberately leaves storage alone
    logic [31:0] r_mem [DEPTH_WORDS] = '{default: '0};

    // The edge entering RESP is the capture edge itself when LATENCY is 0, so the
    // access is described by the live inputs in IDLE and by the captured copy afterwards.
    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_eff_rd   = w_in_idle ? MemRead   : r_rd;
    assign w_eff_wr   = w_in_idle ? MemWrite  : r_wr;
    assign w_eff_addr = w_in_idle ? Address   : r_addr;
    assign w_eff_wdat = w_in_idle ? WriteData : r_wdat;
    assign w_eff_f3   = w_in_idle ? Funct3    : r_f3;

    assign w_eff_err = (w_eff_rd & w_eff_wr) | ~f3_supported(w_eff_f3)
                     | misaligned(w_eff_f3, w_eff_addr[1:0]);

    // Address bits above the storage size are ignored, so addresses wrap
    assign w_idx    = w_eff_addr[AW+1:2];
    assign w_off    = w_eff_addr[1:0];
    assign w_unused = ^w_eff_addr[31:AW+2];

    // Next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_capture    = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (MemRead || MemWrite) begin
                    w_capture = 1'b1;
                    if (LATENCY == 0) begin
                        w_state_nxt  = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = LAT_M1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt  = ST_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Store lane enables and replicated store data
    always_comb begin
        w_be    = 4'b0000;
        w_wlane = w_eff_wdat;
        case (w_eff_f3)
            F3_B: begin
                w_be    = 4'b0001 << w_off;
                w_wlane = {4{w_eff_wdat[7:0]}};
            end
            F3_H: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_eff_wdat[15:0]}};
            end
            F3_W:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_do_wr = w_enter_resp & w_eff_wr & ~w_eff_err;
    assign w_do_rd = w_enter_resp & w_eff_rd & ~w_eff_err;

    // Gate with reset so an edge that arrives while reset is held never commits
    always_ff @(posedge clk) begin
        if (w_do_wr && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
            end
        end
    end

    assign w_rword = r_mem[w_idx];

    load_align u_load_align (
        .i_word   (w_rword),
        .i_offset (w_off),
        .i_funct3 (w_eff_f3),
        .o_data   (w_load)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdat  <= 32'd0;
            r_f3    <= 3'd0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_rd   <= MemRead;
                r_wr   <= MemWrite;
                r_addr <= Address;
                r_wdat <= WriteData;
                r_f3   <= Funct3;
            end
            if (w_enter_resp) r_err   <= w_eff_err;
            if (w_do_rd)      r_rdata <= w_load;
        end
    end

    assign ReadData  = r_rdata;
    assign MemReady  = (r_state == ST_RESP);
    assign Busy      = (r_state != ST_IDLE);
    assign AccessErr = MemReady & r_err;

endmodule
